// File: rtl/cpc_video_pkg.sv
// Shared encodings for the CPC video path: monitor modes and luma weights.
package cpc_video_pkg;

   typedef enum logic [1:0] {
      MON_COLOUR = 2'd0,
      MON_GREEN  = 2'd1,
      MON_AMBER  = 2'd2,
      MON_WHITE  = 2'd3
   } mon_mode_t;

   // Weights sum to 2**LUMA_SHIFT, so the shifted luma never exceeds full scale.
   localparam int LUMA_WR    = 2;
   localparam int LUMA_WG    = 5;
   localparam int LUMA_WB    = 1;
   localparam int LUMA_SHIFT = 3;

endpackage

// File: rtl/cpc_monitor_emu_if.sv
// Pixel/sync/mode-request bundle between the gate-array side and the monitor emulator.
interface cpc_monitor_emu_if #(
   parameter int CW = 3
);
   logic [CW-1:0] ri, gi, bi;
   logic          hsync_n_i, vsync_n_i;
   logic          mode_cycle, mode_force_en;
   logic [1:0]    mode_force;
   logic [CW-1:0] ro, go, bo;
   logic          hsync_n_o, vsync_n_o;
   logic [1:0]    mode_active;

   modport master (
      output ri, gi, bi, hsync_n_i, vsync_n_i, mode_cycle, mode_force_en, mode_force,
      input  ro, go, bo, hsync_n_o, vsync_n_o, mode_active
   );

   modport slave (
      input  ri, gi, bi, hsync_n_i, vsync_n_i, mode_cycle, mode_force_en, mode_force,
      output ro, go, bo, hsync_n_o, vsync_n_o, mode_active
   );
endinterface

// File: rtl/cpc_luma_calc.sv
// Registered luma Y = (2R + 5G + B) >> 3, one clock of latency.
module cpc_luma_calc
   import cpc_video_pkg::*;
#(
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [CW-1:0] r,
   input  logic [CW-1:0] g,
   input  logic [CW-1:0] b,
   output logic [CW-1:0] y_p1
);

   localparam int SW = CW + 3;

   logic [SW-1:0] sum_p0;

   assign sum_p0 = SW'(LUMA_WR) * SW'(r) + SW'(LUMA_WG) * SW'(g) + SW'(LUMA_WB) * SW'(b);

   // p0 -> p1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) y_p1 <= '0;
      else        y_p1 <= CW'(sum_p0 >> LUMA_SHIFT);
   end

endmodule

// File: rtl/cpc_monitor_emu.sv
// CPC monitor emulator: colour/green/amber/white, mode switches applied at vsync fall.
// Optional feature macro: CPC_MON_SWITCH_BLANK_EN (black frames after a mode switch).
module cpc_monitor_emu
   import cpc_video_pkg::*;
#(
   parameter int CW         = 3,
   parameter int MODE_RESET = 0
`ifdef CPC_MON_SWITCH_BLANK_EN
   ,
   parameter int BLANK_FRAMES = 2
`endif
) (
   input logic              clk,
   input logic              pown_reset_n,
   cpc_monitor_emu_if.slave vid
);

   localparam mon_mode_t MODE_INIT = mon_mode_t'(2'(MODE_RESET));

   function automatic logic [3*CW-1:0] map_pixel(input mon_mode_t m, input logic [CW-1:0] r,
                                                 input logic [CW-1:0] g, input logic [CW-1:0] b,
                                                 input logic [CW-1:0] y);
      logic [3*CW-1:0] pix;
      case (m)
         MON_GREEN: pix = {y >> 2, y, y >> 3};
         MON_AMBER: pix = {y, y - (y >> 2), {CW{1'b0}}};
         MON_WHITE: pix = {y, y, y};
         default:   pix = {r, g, b};
      endcase
      return pix;
   endfunction

   mon_mode_t     pending, active, pending_next;
   logic          cycle_prev, vs_prev;
   logic          cycle_rise, vs_fall;
   logic [CW-1:0] r_p1, g_p1, b_p1, y_p1;
   logic          hs_p1, vs_p1;
   logic          blank;

   assign cycle_rise = vid.mode_cycle & ~cycle_prev;
   assign vs_fall    = vs_prev & ~vid.vsync_n_i;

   always_comb begin
      pending_next = pending;
      if (vid.mode_force_en)   pending_next = mon_mode_t'(vid.mode_force);
      else if (cycle_rise)     pending_next = mon_mode_t'(pending + 2'd1);
   end

   // A request landing on the vsync-fall clock is folded into that frame's mode.
   always_ff @(posedge clk or negedge pown_reset_n) begin
      if (!pown_reset_n) begin
         pending    <= MODE_INIT;
         active     <= MODE_INIT;
         cycle_prev <= 1'b0;
         vs_prev    <= 1'b0;
      end else begin
         pending    <= pending_next;
         cycle_prev <= vid.mode_cycle;
         vs_prev    <= vid.vsync_n_i;
         if (vs_fall) active <= pending_next;
      end
   end

`ifdef CPC_MON_SWITCH_BLANK_EN
   logic [2:0] blank_cnt;

   always_ff @(posedge clk or negedge pown_reset_n) begin
      if (!pown_reset_n) begin
         blank_cnt <= 3'd0;
      end else if (vs_fall) begin
         if (pending_next != active) blank_cnt <= 3'(BLANK_FRAMES);
         else if (blank_cnt != 3'd0) blank_cnt <= blank_cnt - 3'd1;
      end
   end

   assign blank = (blank_cnt != 3'd0);
`else
   assign blank = 1'b0;
`endif

   cpc_luma_calc #(.CW(CW)) u_luma (
      .clk  (clk),
      .rst_n(pown_reset_n),
      .r    (vid.ri),
      .g    (vid.gi),
      .b    (vid.bi),
      .y_p1 (y_p1)
   );

   // p0 -> p1: raw colour and syncs alongside the luma
   always_ff @(posedge clk or negedge pown_reset_n) begin
      if (!pown_reset_n) begin
         r_p1  <= '0;
         g_p1  <= '0;
         b_p1  <= '0;
         hs_p1 <= 1'b1;
         vs_p1 <= 1'b1;
      end else begin
         r_p1  <= vid.ri;
         g_p1  <= vid.gi;
         b_p1  <= vid.bi;
         hs_p1 <= vid.hsync_n_i;
         vs_p1 <= vid.vsync_n_i;
      end
   end

   // p1 -> p2: mode mapping and output registers
   always_ff @(posedge clk or negedge pown_reset_n) begin
      if (!pown_reset_n) begin
         {vid.ro, vid.go, vid.bo} <= '0;
         vid.hsync_n_o            <= 1'b1;
         vid.vsync_n_o            <= 1'b1;
      end else begin
         {vid.ro, vid.go, vid.bo} <= blank ? '0 : map_pixel(active, r_p1, g_p1, b_p1, y_p1);
         vid.hsync_n_o            <= hs_p1;
         vid.vsync_n_o            <= vs_p1;
      end
   end

   assign vid.mode_active = active;

endmodule

// File: tb/tb_cpc_monitor_emu.sv
// Directed bench for cpc_monitor_emu (CW=3, MODE_RESET=0); honours CPC_MON_SWITCH_BLANK_EN.
module tb_cpc_monitor_emu;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   cpc_monitor_emu_if #(.CW(3)) vif ();

   cpc_monitor_emu #(.CW(3), .MODE_RESET(0)) dut (
      .clk         (clk),
      .pown_reset_n(rst_n),
      .vid         (vif)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pix(input logic [2:0] r, input logic [2:0] g, input logic [2:0] b);
      vif.ri = r;
      vif.gi = g;
      vif.bi = b;
   endtask

   task automatic force_mode(input logic [1:0] m);
      vif.mode_force_en = 1'b1;
      vif.mode_force    = m;
      step();
      vif.mode_force_en = 1'b0;
   endtask

   task automatic new_frame();
      vif.vsync_n_i = 1'b0;
      step();
      vif.vsync_n_i = 1'b1;
      step();
      step();
   endtask

   task automatic settle_switch();
`ifdef CPC_MON_SWITCH_BLANK_EN
      new_frame();
      new_frame();
`endif
   endtask

   task automatic test_reset();
      set_pix(3'd5, 3'd3, 3'd1);
      step();
      checks++;
      if ({vif.ro, vif.go, vif.bo} !== 9'h000) begin
         errors++;
         $display("FAIL reset_pix got %h want 000", {vif.ro, vif.go, vif.bo});
      end
      checks++;
      if ({vif.hsync_n_o, vif.vsync_n_o} !== 2'b11) begin
         errors++;
         $display("FAIL reset_sync got %b want 11", {vif.hsync_n_o, vif.vsync_n_o});
      end
      checks++;
      if (vif.mode_active !== 2'd0) begin
         errors++;
         $display("FAIL reset_mode got %0d want 0", vif.mode_active);
      end
      set_pix(3'd0, 3'd0, 3'd0);
   endtask

   task automatic test_colour();
      set_pix(3'd5, 3'd3, 3'd1);
      vif.hsync_n_i = 1'b0;
      vif.vsync_n_i = 1'b0;
      step();
      checks++;
      if ({vif.ro, vif.go, vif.bo, vif.hsync_n_o} !== {9'h000, 1'b1}) begin
         errors++;
         $display("FAIL colour_lat1 got %h want 001", {vif.ro, vif.go, vif.bo, vif.hsync_n_o});
      end
      set_pix(3'd0, 3'd0, 3'd0);
      vif.hsync_n_i = 1'b1;
      vif.vsync_n_i = 1'b1;
      step();
      checks++;
      if ({vif.ro, vif.go, vif.bo} !== {3'd5, 3'd3, 3'd1}) begin
         errors++;
         $display("FAIL colour_pix got %h want %h", {vif.ro, vif.go, vif.bo}, {3'd5, 3'd3, 3'd1});
      end
      checks++;
      if ({vif.hsync_n_o, vif.vsync_n_o} !== 2'b00) begin
         errors++;
         $display("FAIL colour_sync got %b want 00", {vif.hsync_n_o, vif.vsync_n_o});
      end
      step();
      checks++;
      if ({vif.ro, vif.go, vif.bo, vif.hsync_n_o, vif.vsync_n_o} !== {9'h000, 2'b11}) begin
         errors++;
         $display("FAIL colour_lat3 got %h want 003",
                  {vif.ro, vif.go, vif.bo, vif.hsync_n_o, vif.vsync_n_o});
      end
   endtask

   task automatic test_green();
      force_mode(2'd1);
      set_pix(3'd7, 3'd7, 3'd7);
      step();
      step();
      checks++;
      if ({vif.ro, vif.go, vif.bo, vif.mode_active} !== {3'd7, 3'd7, 3'd7, 2'd0}) begin
         errors++;
         $display("FAIL green_midframe got %h want %h",
                  {vif.ro, vif.go, vif.bo, vif.mode_active}, {3'd7, 3'd7, 3'd7, 2'd0});
      end
      new_frame();
      checks++;
      if (vif.mode_active !== 2'd1) begin
         errors++;
         $display("FAIL green_active got %0d want 1", vif.mode_active);
      end
      settle_switch();
      checks++;
      if ({vif.ro, vif.go, vif.bo} !== {3'd1, 3'd7, 3'd0}) begin
         errors++;
         $display("FAIL green_y7 got %h want %h", {vif.ro, vif.go, vif.bo}, {3'd1, 3'd7, 3'd0});
      end
      set_pix(3'd0, 3'd4, 3'd0);
      step();
      step();
      checks++;
      if ({vif.ro, vif.go, vif.bo} !== {3'd0, 3'd2, 3'd0}) begin
         errors++;
         $display("FAIL green_y2 got %h want %h", {vif.ro, vif.go, vif.bo}, {3'd0, 3'd2, 3'd0});
      end
   endtask

   task automatic test_amber_white();
      force_mode(2'd2);
      set_pix(3'd7, 3'd7, 3'd7);
      new_frame();
      settle_switch();
      checks++;
      if ({vif.ro, vif.go, vif.bo} !== {3'd7, 3'd6, 3'd0}) begin
         errors++;
         $display("FAIL amber_y7 got %h want %h", {vif.ro, vif.go, vif.bo}, {3'd7, 3'd6, 3'd0});
      end
      force_mode(2'd3);
      set_pix(3'd7, 3'd0, 3'd0);
      new_frame();
      settle_switch();
      checks++;
      if ({vif.ro, vif.go, vif.bo, vif.mode_active} !== {3'd1, 3'd1, 3'd1, 2'd3}) begin
         errors++;
         $display("FAIL white_y1 got %h want %h",
                  {vif.ro, vif.go, vif.bo, vif.mode_active}, {3'd1, 3'd1, 3'd1, 2'd3});
      end
   endtask

   task automatic test_cycle();
      force_mode(2'd0);
      new_frame();
      settle_switch();
      vif.mode_cycle = 1'b1;
      repeat (100) step();
      vif.mode_cycle = 1'b0;
      step();
      checks++;
      if (vif.mode_active !== 2'd0) begin
         errors++;
         $display("FAIL cycle_midframe got %0d want 0", vif.mode_active);
      end
      new_frame();
      checks++;
      if (vif.mode_active !== 2'd1) begin
         errors++;
         $display("FAIL cycle_held got %0d want 1", vif.mode_active);
      end
      vif.mode_cycle = 1'b1;
      vif.vsync_n_i  = 1'b0;
      step();
      checks++;
      if (vif.mode_active !== 2'd2) begin
         errors++;
         $display("FAIL cycle_same_clock got %0d want 2", vif.mode_active);
      end
      vif.mode_cycle = 1'b0;
      vif.vsync_n_i  = 1'b1;
      step();
      vif.mode_cycle    = 1'b1;
      vif.mode_force_en = 1'b1;
      vif.mode_force    = 2'd0;
      step();
      vif.mode_force_en = 1'b0;
      vif.mode_cycle    = 1'b0;
      new_frame();
      checks++;
      if (vif.mode_active !== 2'd0) begin
         errors++;
         $display("FAIL force_priority got %0d want 0", vif.mode_active);
      end
      settle_switch();
   endtask

`ifdef CPC_MON_SWITCH_BLANK_EN
   task automatic test_blank();
      set_pix(3'd5, 3'd3, 3'd1);
      force_mode(2'd0);
      new_frame();
      checks++;
      if ({vif.ro, vif.go, vif.bo} !== {3'd5, 3'd3, 3'd1}) begin
         errors++;
         $display("FAIL blank_same_mode got %h want %h", {vif.ro, vif.go, vif.bo}, {3'd5, 3'd3, 3'd1});
      end
      set_pix(3'd7, 3'd7, 3'd7);
      force_mode(2'd3);
      vif.hsync_n_i = 1'b0;
      new_frame();
      checks++;
      if ({vif.ro, vif.go, vif.bo, vif.hsync_n_o} !== {9'h000, 1'b0}) begin
         errors++;
         $display("FAIL blank_frame1 got %h want 000", {vif.ro, vif.go, vif.bo, vif.hsync_n_o});
      end
      vif.hsync_n_i = 1'b1;
      new_frame();
      checks++;
      if ({vif.ro, vif.go, vif.bo} !== 9'h000) begin
         errors++;
         $display("FAIL blank_frame2 got %h want 000", {vif.ro, vif.go, vif.bo});
      end
      new_frame();
      checks++;
      if ({vif.ro, vif.go, vif.bo} !== {3'd7, 3'd7, 3'd7}) begin
         errors++;
         $display("FAIL blank_frame3 got %h want %h", {vif.ro, vif.go, vif.bo}, {3'd7, 3'd7, 3'd7});
      end
   endtask
`endif

   task automatic test_reset_mid();
      force_mode(2'd2);
      new_frame();
      settle_switch();
      set_pix(3'd5, 3'd3, 3'd1);
      vif.hsync_n_i = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({vif.ro, vif.go, vif.bo, vif.hsync_n_o, vif.vsync_n_o, vif.mode_active}
          !== {9'h000, 2'b11, 2'd0}) begin
         errors++;
         $display("FAIL reset_mid got %h want 00c",
                  {vif.ro, vif.go, vif.bo, vif.hsync_n_o, vif.vsync_n_o, vif.mode_active});
      end
      step();
      rst_n = 1'b1;
      step();
      checks++;
      if ({vif.ro, vif.go, vif.bo, vif.hsync_n_o} !== {9'h000, 1'b1}) begin
         errors++;
         $display("FAIL reset_release1 got %h want 001", {vif.ro, vif.go, vif.bo, vif.hsync_n_o});
      end
      step();
      checks++;
      if ({vif.ro, vif.go, vif.bo, vif.hsync_n_o} !== {3'd5, 3'd3, 3'd1, 1'b0}) begin
         errors++;
         $display("FAIL reset_release2 got %h want %h",
                  {vif.ro, vif.go, vif.bo, vif.hsync_n_o}, {3'd5, 3'd3, 3'd1, 1'b0});
      end
      vif.hsync_n_i = 1'b1;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog expired got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n             = 1'b0;
      vif.ri            = '0;
      vif.gi            = '0;
      vif.bi            = '0;
      vif.hsync_n_i     = 1'b1;
      vif.vsync_n_i     = 1'b1;
      vif.mode_cycle    = 1'b0;
      vif.mode_force_en = 1'b0;
      vif.mode_force    = 2'd0;
      repeat (3) step();
      test_reset();
      rst_n = 1'b1;
      repeat (3) step();
      test_colour();
      test_green();
      test_amber_white();
      test_cycle();
`ifdef CPC_MON_SWITCH_BLANK_EN
      test_blank();
`endif
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
